// File: rtl/bnn_pkg.sv
// Shared constants for the binary conv/maxpool pipeline and the stream reader.
// Holds the default layer geometry, the pooled-map bit count and the
// words-per-channel calculation used by the readers.
package bnn_pkg;

   localparam int unsigned DEF_OC       = 8;
   localparam int unsigned DEF_IMG_SIZE = 14;
   localparam int unsigned DEF_WORD_W   = 8;

   // Integer ceiling division for compile-time sizing.
   function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
      return (num + den - 1) / den;
   endfunction

   // Counter width that stays at least one bit for degenerate sizes.
   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int unsigned NPIX = DEF_IMG_SIZE * DEF_IMG_SIZE;
   localparam int unsigned WPC  = ceil_div(NPIX, DEF_WORD_W);

endpackage

// File: rtl/fmap_stream_reader_if.sv
// Word stream from the feature-map reader to its consumer.
//   valid/ready : handshake, word accepted when both are high
//   data        : stream word
//   chan        : channel index of the current word
//   last        : last word of the last channel
interface fmap_stream_reader_if
   import bnn_pkg::*;
#(
   parameter int unsigned WORD_W = DEF_WORD_W,
   parameter int unsigned CHAN_W = 3
);

   logic              valid;
   logic [WORD_W-1:0] data;
   logic [CHAN_W-1:0] chan;
   logic              last;
   logic              ready;

   modport master (output valid, data, chan, last, input ready);
   modport slave  (input valid, data, chan, last, output ready);

endinterface

// File: rtl/fmap_word_sel.sv
// Combinational word selector: returns fmap[chan][word*WORD_W +: WORD_W],
// with bits beyond the end of the channel vector reading as zero.
//   fmap   : latched channel vectors
//   chan   : channel index
//   word   : word index within the channel
//   data_c : selected, zero-padded word
module fmap_word_sel #(
   parameter int unsigned OC     = 8,
   parameter int unsigned NBITS  = 196,
   parameter int unsigned WORD_W = 8,
   parameter int unsigned WPC    = 25,
   parameter int unsigned CW     = 3,
   parameter int unsigned WW     = 5
) (
   input  logic [NBITS-1:0]  fmap [OC],
   input  logic [CW-1:0]     chan,
   input  logic [WW-1:0]     word,
   output logic [WORD_W-1:0] data_c
);

   logic [WPC*WORD_W-1:0] padded;

   // Pad the channel vector to a whole number of words before slicing.
   always_comb begin
      padded              = '0;
      padded[NBITS-1:0]   = fmap[chan];
      data_c              = padded[word*WORD_W +: WORD_W];
   end

endmodule

// File: rtl/fmap_stream_reader.sv
// Read-side partner of a conv+maxpool layer. Holds layer_go high until the
// layer reports done, latches every pooled map on that edge, drops layer_go
// (clearing the layer) and streams the maps out channel-major as words.
//   clk, rst   : clock, synchronous active-high reset
//   start      : request one pass, honoured only when idle
//   layer_go   : level to the layer, high while the pass runs
//   layer_done : layer result valid
//   fmap_in    : layer output maps, one vector per channel
//   m          : word stream (master side)
//   busy       : high whenever not idle
//   done       : one-cycle pulse after the final word handshake
module fmap_stream_reader
   import bnn_pkg::*;
#(
   parameter int unsigned OC       = DEF_OC,
   parameter int unsigned IMG_SIZE = DEF_IMG_SIZE,
   parameter int unsigned WORD_W   = DEF_WORD_W
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   output logic                           layer_go,
   input  logic                           layer_done,
   input  logic [IMG_SIZE*IMG_SIZE-1:0]   fmap_in [OC],
   fmap_stream_reader_if.master           m,
   output logic                           busy,
   output logic                           done
);

   localparam int unsigned NBITS = IMG_SIZE * IMG_SIZE;
   localparam int unsigned WPC_N = ceil_div(NBITS, WORD_W);
   localparam int unsigned CW    = clog2_min1(OC);
   localparam int unsigned WW    = clog2_min1(WPC_N);

   localparam logic [CW-1:0] CHAN_LAST = CW'(OC - 1);
   localparam logic [WW-1:0] WORD_LAST = WW'(WPC_N - 1);
   localparam logic          ONE_WORD  = (OC == 1) && (WPC_N == 1);

   typedef enum logic [1:0] {IDLE, RUN, STREAM} state_t;

   state_t            state;
   logic [NBITS-1:0]  fmap_buf [OC];
   logic [WW-1:0]     word_q;
   logic [WW-1:0]     nxt_word_c;
   logic [CW-1:0]     nxt_chan_c;
   logic              nxt_last_c;
   logic [WORD_W-1:0] nxt_data_c;

   // Index of the word that follows the one currently presented.
   always_comb begin
      nxt_word_c = word_q + WW'(1);
      nxt_chan_c = m.chan;
      if (word_q == WORD_LAST) begin
         nxt_word_c = '0;
         nxt_chan_c = m.chan + CW'(1);
      end
      nxt_last_c = (nxt_chan_c == CHAN_LAST) && (nxt_word_c == WORD_LAST);
   end

   fmap_word_sel #(
      .OC     (OC),
      .NBITS  (NBITS),
      .WORD_W (WORD_W),
      .WPC    (WPC_N),
      .CW     (CW),
      .WW     (WW)
   ) u_word_sel (
      .fmap   (fmap_buf),
      .chan   (nxt_chan_c),
      .word   (nxt_word_c),
      .data_c (nxt_data_c)
   );

   // Map buffer, captured only on the RUN->STREAM edge.
   always_ff @(posedge clk) begin
      if (!rst && state == RUN && layer_done) begin
         fmap_buf <= fmap_in;
      end
   end

   // Pass sequencer with registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         layer_go <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         word_q   <= '0;
         m.valid  <= 1'b0;
         m.data   <= '0;
         m.chan   <= '0;
         m.last   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state    <= RUN;
                  layer_go <= 1'b1;
                  busy     <= 1'b1;
               end
            end
            RUN: begin
               if (layer_done) begin
                  // Word 0 of channel 0 comes straight from the layer since
                  // the buffer is being written on this same edge.
                  state    <= STREAM;
                  layer_go <= 1'b0;
                  word_q   <= '0;
                  m.chan   <= '0;
                  m.valid  <= 1'b1;
                  m.data   <= WORD_W'(fmap_in[0]);
                  m.last   <= ONE_WORD;
               end
            end
            STREAM: begin
               if (m.ready) begin
                  if (m.last) begin
                     state   <= IDLE;
                     m.valid <= 1'b0;
                     m.last  <= 1'b0;
                     busy    <= 1'b0;
                     done    <= 1'b1;
                  end else begin
                     word_q <= nxt_word_c;
                     m.chan <= nxt_chan_c;
                     m.data <= nxt_data_c;
                     m.last <= nxt_last_c;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fmap_stream_reader.sv
// Randomized scoreboard bench for fmap_stream_reader: a layer model supplies
// maps and pushes the expected word sequence; a monitor pops on handshakes.
module tb_fmap_stream_reader;
   import bnn_pkg::*;

   localparam int unsigned OC     = DEF_OC;
   localparam int unsigned WORD_W = DEF_WORD_W;
   localparam int unsigned NP     = NPIX;
   localparam int unsigned WPCN   = WPC;
   localparam int unsigned CW     = 3;
   localparam int unsigned TOTAL  = OC * WPCN;

   typedef struct packed {
      logic [WORD_W-1:0] data;
      logic [CW-1:0]     chan;
      logic              last;
   } exp_t;

   logic clk = 1'b0;
   logic rst, start, layer_go, layer_done, busy, done;
   logic model_done, spur_done, ready_r;
   logic [NP-1:0] fmap_in [OC];

   int vectors = 0;
   int miscompares = 0;
   int done_count = 0;
   int go_rises = 0;
   int words_in_pass = 0;
   int ready_mode = 0;    // 0: always ready, 1: random 50%
   int fmap_mode = 0;     // 0: formula, 1: random
   bit zero_after = 0;

   exp_t exp_q[$];

   fmap_stream_reader_if #(.WORD_W(WORD_W), .CHAN_W(CW)) s_if ();

   fmap_stream_reader #(.OC(OC), .IMG_SIZE(DEF_IMG_SIZE), .WORD_W(WORD_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .layer_go   (layer_go),
      .layer_done (layer_done),
      .fmap_in    (fmap_in),
      .m          (s_if.master),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   assign layer_done = model_done | spur_done;
   assign s_if.ready = ready_r;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference word: bit k of word w of a channel is pixel bit w*WORD_W+k, zero past the end.
   function automatic logic [WORD_W-1:0] exp_word(input logic [NP-1:0] v, input int unsigned w);
      logic [WORD_W-1:0] r;
      r = '0;
      for (int unsigned k = 0; k < WORD_W; k++) begin
         if (w * WORD_W + k < NP) r[k] = v[w * WORD_W + k];
      end
      return r;
   endfunction

   // Ready driver.
   always @(posedge clk) begin
      #1;
      ready_r = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
   end

   // Layer model: answers a go edge with done after 10 cycles and pushes expectations.
   bit lm_active = 0;
   bit go_prev = 0;
   int lm_cnt = 0;
   always @(posedge clk) begin
      #1;
      if (rst) begin
         model_done = 1'b0;
         lm_active  = 0;
         go_prev    = 0;
      end else begin
         if (layer_go && !go_prev) begin
            go_rises++;
            lm_active = 1;
            lm_cnt    = 0;
         end
         if (model_done) begin
            check("go_fall", 64'(layer_go), 64'd0);
            model_done = 1'b0;
            lm_active  = 0;
            if (zero_after) for (int c = 0; c < OC; c++) fmap_in[c] = '0;
         end else if (lm_active) begin
            lm_cnt++;
            if (lm_cnt == 10) begin
               for (int c = 0; c < OC; c++) begin
                  if (fmap_mode == 0) fmap_in[c] = NP'(32'(c) * 32'h1234567 + 32'd1);
                  else for (int b = 0; b < NP; b++) fmap_in[c][b] = 1'($urandom_range(0, 1));
               end
               for (int c = 0; c < OC; c++) begin
                  for (int w = 0; w < WPCN; w++) begin
                     exp_t e;
                     e.data = exp_word(fmap_in[c], w);
                     e.chan = CW'(c);
                     e.last = (c * WPCN + w == TOTAL - 1);
                     exp_q.push_back(e);
                  end
               end
               model_done = 1'b1;
            end
         end
         go_prev = layer_go;
      end
   end

   // Monitor: pops on handshakes, checks stability under stall, done timing, bubbles.
   bit stall_prev = 0;
   bit hs_last_prev = 0;
   exp_t held;
   exp_t got;
   always @(negedge clk) begin
      if (rst) begin
         words_in_pass = 0;
         stall_prev    = 0;
         hs_last_prev  = 0;
      end else begin
         check("done_pulse", 64'(done), 64'(hs_last_prev));
         if (done) begin
            check("words_per_pass", 64'(words_in_pass), 64'(TOTAL));
            done_count++;
            words_in_pass = 0;
         end
         got = '{data: s_if.data, chan: s_if.chan, last: s_if.last};
         if (stall_prev) check("stall_hold", 64'(got), 64'(held));
         if (ready_mode == 0 && words_in_pass > 0 && words_in_pass < TOTAL)
            check("no_bubble", 64'(s_if.valid), 64'd1);
         hs_last_prev = 0;
         if (s_if.valid && s_if.ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_word", 64'd1, 64'd0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("m_data", 64'(got.data), 64'(e.data));
               check("m_chan", 64'(got.chan), 64'(e.chan));
               check("m_last", 64'(got.last), 64'(e.last));
            end
            if ((words_in_pass % WPCN) == WPCN - 1)
               check("pad_zero", 64'(got.data >> (NP - (WPCN - 1) * WORD_W)), 64'd0);
            words_in_pass++;
            hs_last_prev = s_if.last;
         end
         stall_prev = s_if.valid && !s_if.ready;
         held       = got;
      end
   end

   task automatic start_pass();
      @(posedge clk); #2 start = 1'b1;
      @(posedge clk); #2 start = 1'b0;
   endtask

   task automatic wait_done_count(input int target, input int budget);
      int n = 0;
      while (done_count < target && n < budget) begin
         @(posedge clk);
         n++;
      end
      check("wait_done_timeout", 64'(done_count >= target), 64'd1);
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while ((busy || layer_go) && n < budget) begin
         @(posedge clk);
         n++;
      end
      check("wait_idle_timeout", 64'(busy || layer_go), 64'd0);
   endtask

   task automatic check_reset_outputs();
      check("rst_layer_go", 64'(layer_go), 64'd0);
      check("rst_busy",     64'(busy),     64'd0);
      check("rst_done",     64'(done),     64'd0);
      check("rst_m_valid",  64'(s_if.valid), 64'd0);
      check("rst_m_data",   64'(s_if.data),  64'd0);
      check("rst_m_chan",   64'(s_if.chan),  64'd0);
      check("rst_m_last",   64'(s_if.last),  64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int base_go, base_done, n;
      rst = 1'b1; start = 1'b0; spur_done = 1'b0; ready_r = 1'b1;
      for (int c = 0; c < OC; c++) fmap_in[c] = '0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      check_reset_outputs();

      // Basic pass, consumer always ready, formula maps.
      start_pass();
      wait_done_count(1, 600);

      // Backpressure with the same maps.
      ready_mode = 1;
      start_pass();
      wait_done_count(2, 2000);

      // Capture timing: maps zeroed right after the done edge, random content.
      ready_mode = 0; fmap_mode = 1; zero_after = 1;
      start_pass();
      wait_done_count(3, 600);
      zero_after = 0;

      // Reset for two cycles mid-stream, then a fresh pass.
      ready_mode = 1;
      start_pass();
      n = 0;
      while (words_in_pass < 50 && n < 2000) begin @(posedge clk); n++; end
      check("reach_midstream", 64'(words_in_pass >= 50), 64'd1);
      @(posedge clk); #2 rst = 1'b1;
      exp_q.delete();
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      check_reset_outputs();
      start_pass();
      wait_done_count(4, 2000);

      // Spurious start in RUN and STREAM, spurious layer_done in IDLE.
      ready_mode = 0; fmap_mode = 0;
      base_go = go_rises; base_done = done_count;
      start_pass();
      @(posedge clk); #2 start = 1'b1;
      @(posedge clk); #2 start = 1'b0;
      n = 0;
      while (!s_if.valid && n < 100) begin @(posedge clk); n++; end
      #2 start = 1'b1;
      @(posedge clk); #2 start = 1'b0;
      wait_done_count(base_done + 1, 600);
      repeat (3) @(posedge clk);
      #2 spur_done = 1'b1;
      @(posedge clk); #2 spur_done = 1'b0;
      repeat (20) @(posedge clk);
      @(negedge clk);
      check("spur_busy",   64'(busy),     64'd0);
      check("spur_go",     64'(layer_go), 64'd0);
      check("spur_passes", 64'(go_rises - base_go), 64'd1);
      check("spur_dones",  64'(done_count - base_done), 64'd1);

      // Start held high: passes repeat, one go edge per completed pass.
      ready_mode = 1; fmap_mode = 1;
      base_go = go_rises; base_done = done_count;
      @(posedge clk); #2 start = 1'b1;
      wait_done_count(base_done + 3, 6000);
      #2 start = 1'b0;
      wait_idle(2000);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("b2b_go_per_pass", 64'(go_rises - base_go), 64'(done_count - base_done));
      check("b2b_min_passes", 64'(done_count - base_done >= 3), 64'd1);
      check("queue_drained", 64'(exp_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
